mapa_multicanal: RTL

- Parametrised successor to the game-map cell memory: a W×H grid of CELL_BITS-wide cells shared by N_CANAIS requesters (snake(s), fruit, obstacle generators) plus an independent VGA read port.
- Adds round-robin arbitration with a req/gnt handshake and read-before-write of the old cell value, used for collision detection.
- Adds an out-of-range flag and a sequential hardware clear on reset or on command.
- Sits between the game-logic FSMs and the VGA renderer.

---
 rtl/mapa_multicanal.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mapa_multicanal.sv
`default_nettype none
// ============================================================================
// Module   : mapa_multicanal
// Brief    : Multi-channel game-map cell memory with round-robin arbitration,
//            read-before-write results, hardware clear and a VGA read port.
// Revision : 1.0 - initial release
// ============================================================================
module mapa_multicanal #(
    parameter int MAPA_WIDTH  = 32,
    parameter int MAPA_HEIGHT = 24,
    parameter int CELL_BITS   = 4,
    parameter int N_CANAIS    = 3,
    localparam int CW         = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          limpar,
    output logic                          ocupado,
    input  logic [N_CANAIS-1:0]           req,
    input  logic [N_CANAIS-1:0]           we,
    input  logic [N_CANAIS*10-1:0]        x,
    input  logic [N_CANAIS*10-1:0]        y,
    input  logic [N_CANAIS*CELL_BITS-1:0] wdado,
    output logic [N_CANAIS-1:0]           gnt,
    output logic [CELL_BITS-1:0]          rdado,
    output logic                          rvalido,
    output logic [CW-1:0]                 rcanal,
    output logic                          fora,
    input  logic [9:0]                    vga_x,
    input  logic [9:0]                    vga_y,
    output logic [CELL_BITS-1:0]          vga_dado
);

    localparam int c_DEPTH = MAPA_WIDTH * MAPA_HEIGHT;
    localparam int c_AW    = $clog2(c_DEPTH) + 1;
    localparam int c_IW    = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;

    typedef enum logic [0:0] {
        LIMPANDO = 1'b0,
        PRONTO   = 1'b1
    } estado_t;

    estado_t              r_estado;
    estado_t              w_estado_prox;
    logic [c_AW-1:0]      r_cnt;
    logic [CW-1:0]        r_ptr;
    logic [CELL_BITS-1:0] r_mem [c_DEPTH];

    logic [CELL_BITS-1:0] r_rdado;
    logic                 r_rvalido;
    logic [CW-1:0]        r_rcanal;
    logic                 r_fora;
    logic [CELL_BITS-1:0] r_vga_dado;

    logic                 w_achou;
    logic [CW-1:0]        w_sel;
    logic                 w_gnt_ok;
    logic [9:0]           w_x;
    logic [9:0]           w_y;
    logic [c_AW-1:0]      w_addr;
    logic                 w_dentro;
    logic                 w_we;
    logic [CELL_BITS-1:0] w_wd;
    logic [c_AW-1:0]      w_vga_addr;
    logic                 w_vga_dentro;

    // Round-robin scan starting at r_ptr; first requester found wins.
    always_comb begin : p_arb
        logic [CW:0] v_idx;
        w_achou = 1'b0;
        w_sel   = '0;
        v_idx   = '0;
        for (int k = 0; k < N_CANAIS; k++) begin
            v_idx = {1'b0, r_ptr} + (CW+1)'(k);
            if (v_idx >= (CW+1)'(N_CANAIS))
                v_idx = v_idx - (CW+1)'(N_CANAIS);
            if (!w_achou && req[v_idx[CW-1:0]]) begin
                w_achou = 1'b1;
                w_sel   = v_idx[CW-1:0];
            end
        end
    end

    assign w_gnt_ok = (r_estado == PRONTO) && !limpar && !reset && w_achou;
    assign gnt      = w_gnt_ok ? (N_CANAIS'(1) << w_sel) : '0;

    assign w_x  = x[w_sel*10 +: 10];
    assign w_y  = y[w_sel*10 +: 10];
    assign w_we = we[w_sel];
    assign w_wd = wdado[w_sel*CELL_BITS +: CELL_BITS];

    // Coordinates are range-checked at full width before the address is formed.
    assign w_addr   = c_AW'(w_y) * c_AW'(MAPA_WIDTH) + c_AW'(w_x);
    assign w_dentro = (w_x < 10'(MAPA_WIDTH)) && (w_y < 10'(MAPA_HEIGHT))
                      && (w_addr < c_AW'(c_DEPTH));

    assign w_vga_addr   = c_AW'(vga_y) * c_AW'(MAPA_WIDTH) + c_AW'(vga_x);
    assign w_vga_dentro = (vga_x < 10'(MAPA_WIDTH)) && (vga_y < 10'(MAPA_HEIGHT))
                          && (w_vga_addr < c_AW'(c_DEPTH));

    always_comb begin
        w_estado_prox = r_estado;
        case (r_estado)
            LIMPANDO: if (r_cnt == c_AW'(c_DEPTH - 1)) w_estado_prox = PRONTO;
            PRONTO:   if (limpar) w_estado_prox = LIMPANDO;
            default:  w_estado_prox = LIMPANDO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado <= LIMPANDO;
            r_cnt    <= '0;
        end else begin
            r_estado <= w_estado_prox;
            r_cnt    <= ((r_estado == LIMPANDO) && (w_estado_prox == LIMPANDO))
                        ? r_cnt + c_AW'(1) : '0;
        end
    end

    // Single write port: the clear sweep and granted writes never overlap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_estado == LIMPANDO)
                r_mem[r_cnt[c_IW-1:0]] <= '0;
            else if (w_gnt_ok && w_dentro && w_we)
                r_mem[w_addr[c_IW-1:0]] <= w_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr      <= '0;
            r_rdado    <= '0;
            r_rvalido  <= 1'b0;
            r_rcanal   <= '0;
            r_fora     <= 1'b0;
            r_vga_dado <= '0;
        end else begin
            r_rvalido  <= w_gnt_ok;
            r_fora     <= w_gnt_ok && !w_dentro;
            r_vga_dado <= w_vga_dentro ? r_mem[w_vga_addr[c_IW-1:0]] : '0;
            if (w_gnt_ok) begin
                r_rdado  <= w_dentro ? r_mem[w_addr[c_IW-1:0]] : '0;
                r_rcanal <= w_sel;
                r_ptr    <= (w_sel == CW'(N_CANAIS - 1)) ? '0 : w_sel + CW'(1);
            end
        end
    end

    assign ocupado  = (r_estado == LIMPANDO);
    assign rdado    = r_rdado;
    assign rvalido  = r_rvalido;
    assign rcanal   = r_rcanal;
    assign fora     = r_fora;
    assign vga_dado = r_vga_dado;

endmodule
`default_nettype wire
